// File: rtl/mips_pkg.sv
// Shared pipeline definitions: register-number width, memory latency default,
// hazard FSM states and the register dependency compare.
package mips_pkg;

  localparam int unsigned REG_W       = 5;
  localparam int unsigned MEM_LAT_DEF = 6;
  localparam int unsigned CNT_W       = 4;
  localparam int unsigned STALL_W     = 16;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_MEM_DONE = 2'd2
  } hz_state_e;

  typedef struct packed {
    logic             wb_en;
    logic [REG_W-1:0] dest;
  } wb_src_t;

  // Register 0 is hardwired to zero, so a write to it never creates a dependency.
  function automatic logic reg_hit(input wb_src_t w, input logic [REG_W-1:0] s1,
                                   input logic [REG_W-1:0] s2, input logic two_src);
    return w.wb_en && (w.dest != '0) && ((w.dest == s1) || (two_src && (w.dest == s2)));
  endfunction

endpackage

// File: rtl/hazard_detect.sv
// Combinational RAW-hazard compare of the ID sources against the EXE and MEM
// destinations.
module hazard_detect
  import mips_pkg::*;
#(
  parameter bit FORWARD_EN = 1'b0
) (
  input  logic [REG_W-1:0] src1,
  input  logic [REG_W-1:0] src2,
  input  logic             two_src,
  input  logic             exe_wb_en,
  input  logic             exe_mem_read,
  input  logic [REG_W-1:0] exe_dest,
  input  logic             mem_wb_en,
  input  logic [REG_W-1:0] mem_dest,
  output logic             hazard
);

  logic exe_hit;
  logic mem_hit;

  assign exe_hit = reg_hit('{wb_en: exe_wb_en, dest: exe_dest}, src1, src2, two_src);
  assign mem_hit = reg_hit('{wb_en: mem_wb_en, dest: mem_dest}, src1, src2, two_src);

  // With forwarding only a load still in EXE cannot supply its result in time.
  assign hazard = FORWARD_EN ? (exe_hit & exe_mem_read) : (exe_hit | mem_hit);

endmodule

// File: rtl/hazard_controller.sv
// Pipeline hazard controller: memory-latency stall FSM, branch flush and
// load-use freeze with a fixed priority, plus a saturating stall counter.
module hazard_controller
  import mips_pkg::*;
#(
  parameter int unsigned MEM_LAT    = MEM_LAT_DEF,
  parameter bit          FORWARD_EN = 1'b0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [REG_W-1:0]   src1,
  input  logic [REG_W-1:0]   src2,
  input  logic               twoSoursec,
  input  logic               exe_wb_en,
  input  logic               exe_mem_read,
  input  logic [REG_W-1:0]   exe_dest,
  input  logic               mem_wb_en,
  input  logic [REG_W-1:0]   mem_dest,
  input  logic               mem_req,
  input  logic               br_taken,
  output logic               freez,
  output logic               flush_ifid,
  output logic               pipe_stall,
  output logic               mem_done,
  output logic [STALL_W-1:0] stall_cycles
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MEM_LAT - 1);

  hz_state_e          state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [STALL_W-1:0] stall_cycles_q, stall_cycles_d;
  logic               hazard;
  logic               stall_int;

  hazard_detect #(.FORWARD_EN(FORWARD_EN)) u_detect (
    .src1         (src1),
    .src2         (src2),
    .two_src      (twoSoursec),
    .exe_wb_en    (exe_wb_en),
    .exe_mem_read (exe_mem_read),
    .exe_dest     (exe_dest),
    .mem_wb_en    (mem_wb_en),
    .mem_dest     (mem_dest),
    .hazard       (hazard)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_RUN: begin
        if (mem_req) begin
          state_d = ST_MEM_WAIT;
          cnt_d   = 4'd1;
        end
      end
      ST_MEM_WAIT: begin
        if (cnt_q == LAST_CNT) state_d = ST_MEM_DONE;
        else                   cnt_d   = cnt_q + 4'd1;
      end
      ST_MEM_DONE: begin
        state_d = ST_RUN;
        cnt_d   = '0;
      end
      default: begin
        state_d = ST_RUN;
        cnt_d   = '0;
      end
    endcase
  end

  // The request cycle itself stalls, so one access freezes exactly MEM_LAT cycles.
  assign stall_int  = ((state_q == ST_RUN) && mem_req) || (state_q == ST_MEM_WAIT);

  assign pipe_stall = !rst && stall_int;
  assign mem_done   = !rst && (state_q == ST_MEM_DONE);
  assign flush_ifid = !rst && !stall_int && br_taken;
  assign freez      = !rst && !stall_int && !br_taken && hazard;

  always_comb begin
    stall_cycles_d = stall_cycles_q;
    if ((pipe_stall || freez) && (stall_cycles_q != '1))
      stall_cycles_d = stall_cycles_q + 16'd1;
  end

  assign stall_cycles = rst ? '0 : stall_cycles_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_RUN;
      cnt_q          <= '0;
      stall_cycles_q <= '0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end

endmodule
